// File: rtl/lcd_bus_responder.sv
// HD44780-style 8-bit LCD bus responder: 2x16 DDRAM shadow, AC, flags, busy timing.
// Optional LCD_INIT_CHECK_EN: drop data accesses until the first function set.
module lcd_bus_responder #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] DB_in,
    output logic [7:0] DB_out,
    output logic       DB_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       overrun,
`ifdef LCD_INIT_CHECK_EN
    output logic       init_err,
`endif
    output logic       addr_err
);

    localparam int unsigned MAX_CYCLES =
        (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [3:0] {
        OP_NONE,
        OP_STATUS,
        OP_RD,
        OP_WR,
        OP_DDRAM,
        OP_CGRAM,
        OP_FUNC,
        OP_SHIFT,
        OP_DISP,
        OP_ENTRY,
        OP_HOME,
        OP_CLEAR,
        OP_NOP
    } op_e;

    logic          e_q;
    logic          armed;
    logic          rs_q;
    logic          rw_q;
    logic [7:0]    db_q;
    logic          fall;
    op_e           op;
    logic [CW-1:0] busy_cnt;
    logic [7:0]    shadow [32];
    logic          id_inc;
    logic          data_ok;
    logic [4:0]    ac_idx;
    logic [6:0]    ac_inc;
    logic [6:0]    ac_dec;
    logic [6:0]    ac_step;
    logic          ddram_ok;

    // armed blocks a pulse that was already high when reset released
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_q   <= 1'b0;
            armed <= 1'b0;
            rs_q  <= 1'b0;
            rw_q  <= 1'b0;
            db_q  <= 8'h00;
        end else begin
            armed <= armed | ~E;
            e_q   <= E & armed;
            if (E) begin
                rs_q <= RS;
                rw_q <= RW;
                db_q <= DB_in;
            end
        end
    end

    assign fall     = e_q & ~E;
    assign busy     = (busy_cnt != '0);
    assign ac_idx   = {ac[6], ac[3:0]};
    assign rd_char  = shadow[rd_addr];
    assign DB_oe    = E & RW;
    assign ddram_ok = (db_q[5:4] == 2'b00);

    // stepping wraps between the two 16-column windows
    always_comb begin
        ac_inc = ac + 7'd1;
        ac_dec = ac - 7'd1;
        if (ac[3:0] == 4'hF) ac_inc = ac[6] ? 7'h00 : 7'h40;
        if (ac[3:0] == 4'h0) ac_dec = ac[6] ? 7'h0F : 7'h4F;
        ac_step = id_inc ? ac_inc : ac_dec;
    end

    always_comb begin
        DB_out = 8'h00;
        if (E && RW) begin
            if (RS) DB_out = data_ok ? shadow[ac_idx] : 8'h00;
            else    DB_out = {busy, ac};
        end
    end

    always_comb begin
        op = OP_NONE;
        if (fall) begin
            if (rw_q) begin
                op = rs_q ? OP_RD : OP_STATUS;
            end else if (rs_q) begin
                op = OP_WR;
            end else begin
                unique case (1'b1)
                    db_q[7]:              op = OP_DDRAM;
                    db_q[7:6] == 2'b01:   op = OP_CGRAM;
                    db_q[7:5] == 3'b001:  op = OP_FUNC;
                    db_q[7:4] == 4'b0001: op = OP_SHIFT;
                    db_q[7:3] == 5'b00001: op = OP_DISP;
                    db_q[7:2] == 6'b000001: op = OP_ENTRY;
                    db_q[7:1] == 7'b0000001: op = OP_HOME;
                    db_q == 8'h01:        op = OP_CLEAR;
                    default:              op = OP_NOP;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
            ac         <= 7'h00;
            id_inc     <= 1'b1;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            two_line   <= 1'b0;
            busy_cnt   <= '0;
            overrun    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            if (busy) busy_cnt <= busy_cnt - CNT_ONE;
            case (op)
                OP_NONE, OP_STATUS: ;
                OP_RD: begin
                    if (data_ok) begin
                        if (busy) begin
                            overrun <= 1'b1;
                        end else begin
                            ac       <= ac_step;
                            busy_cnt <= BUSY_LOAD;
                        end
                    end
                end
                OP_WR: begin
                    if (data_ok) begin
                        if (busy) begin
                            overrun <= 1'b1;
                        end else begin
                            shadow[ac_idx] <= db_q;
                            ac             <= ac_step;
                            busy_cnt       <= BUSY_LOAD;
                        end
                    end
                end
                default: begin
                    if (busy) begin
                        overrun <= 1'b1;
                    end else begin
                        busy_cnt <= BUSY_LOAD;
                        case (op)
                            OP_DDRAM: begin
                                if (ddram_ok) begin
                                    ac <= db_q[6:0];
                                end else begin
                                    ac       <= {db_q[6], 2'b00, db_q[3:0]};
                                    addr_err <= 1'b1;
                                end
                            end
                            OP_FUNC: two_line <= db_q[3];
                            OP_SHIFT: begin
                                if (!db_q[3]) ac <= db_q[2] ? ac_inc : ac_dec;
                            end
                            OP_DISP: begin
                                display_on <= db_q[2];
                                cursor_on  <= db_q[1];
                                blink_on   <= db_q[0];
                            end
                            OP_ENTRY: id_inc <= db_q[1];
                            OP_HOME: begin
                                ac       <= 7'h00;
                                busy_cnt <= CLEAR_LOAD;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
                                ac       <= 7'h00;
                                id_inc   <= 1'b1;
                                busy_cnt <= CLEAR_LOAD;
                            end
                            OP_NOP: busy_cnt <= '0;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef LCD_INIT_CHECK_EN
    logic init_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
        end else begin
            if ((op == OP_RD || op == OP_WR) && !init_done) init_err <= 1'b1;
            if (op == OP_FUNC && !busy) init_done <= 1'b1;
        end
    end

    assign data_ok = init_done;
`else
    assign data_ok = 1'b1;
`endif

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Bus-level responder for the HD44780-style 8-bit LCD interface (RS, RW, E, DB) driven by the output stage's LCD writer.
- Decodes instructions and data writes and keeps a 2x16 DDRAM shadow, an address counter (AC) and the display flags.
- Answers read cycles with busy flag/AC or DDRAM data.
- Used on-chip as a loopback checker and in benches as the LCD model, with cycle-accurate busy timing.

Parameters:
- BUSY_CYCLES, 2000: busy duration after an ordinary command or data access (40 us at 50 MHz).
- CLEAR_CYCLES, 82000: busy duration after clear display / return home (1.64 ms at 50 MHz).

Ports:
- clock  in  1  system clock (50 MHz domain, same clock as the LCD writer).
- reset  in  1  asynchronous, active-high reset.
- RS  in  1  register select: 0 = instruction/status, 1 = data.
- RW  in  1  0 = write, 1 = read.
- E  in  1  enable strobe.
- DB_in  in  8  bus value driven by the writer.
- DB_out  out  8  read data.
- DB_oe  out  1  high while the responder drives the bus.
- rd_addr  in  5  shadow peek index: {line, column[3:0]}.
- rd_char  out  8  combinational shadow content at rd_addr.
- ac  out  7  address counter.
- busy  out  1  busy flag.
- display_on, cursor_on, blink_on, two_line  out  1 each  decoded control flags.
- overrun  out  1  sticky: a write arrived while busy.
- addr_err  out  1  sticky: a DDRAM address was set outside 0x00-0x0F / 0x40-0x4F.

Behaviour:
- Reset values:
  - Shadow: all 32 entries = 0x20.
  - ac = 0, increment mode (I/D = 1).
  - display_on, cursor_on, blink_on, two_line = 0.
  - busy, overrun, addr_err = 0.
  - DB_oe = 0, DB_out = 0, busy counter = 0.
- Bus capture:
  - E is registered as e_q. RS, RW and DB_in are captured every cycle E = 1.
  - Falling edge = e_q & ~E. Commit happens on the falling-edge cycle; state is visible the next cycle (1-cycle latency).
- Reads (RW = 1):
  - DB_oe = E & RW, combinational.
  - RS = 0: DB_out = {busy, ac}. Status reads are allowed while busy and have no side effects.
  - RS = 1: DB_out = shadow[ac], held while E is high. On the falling edge, ac steps per I/D and busy loads BUSY_CYCLES.
  - A data read while busy returns data but does not step ac. It sets overrun.
- Writes while busy: ignored entirely; overrun set.
- Busy counter:
  - Loads BUSY_CYCLES or CLEAR_CYCLES on commit; busy = (counter != 0).
  - Decrements each cycle and is exactly N cycles high.
- Instruction decode (RS = 0, RW = 0), priority on the highest set bit:
  - 1aaaaaaa, set DDRAM address: ac = DB[6:0] if valid. Otherwise ac = {DB[6], 2'b00, DB[3:0]} and addr_err = 1.
  - 01xxxxxx, CGRAM address: no effect except busy.
  - 001xNxxx, function set: two_line = N.
  - 0001SRxx, shift: S = 0 steps ac by R (1 = +1, 0 = -1). S = 1 has no effect. Busy in both cases.
  - 00001DCB, display control: display_on = D, cursor_on = C, blink_on = B.
  - 000001Ix, entry mode: I/D = I. The shift bit is ignored.
  - 0000001x, return home: ac = 0; busy CLEAR_CYCLES.
  - 00000001, clear: all shadow entries = 0x20, ac = 0, I/D = 1; busy CLEAR_CYCLES.
  - 0x00: no-op; busy is not loaded.
- Data write (RS = 1, RW = 0): shadow[{ac[6], ac[3:0]}] = DB; ac steps; busy BUSY_CYCLES.
- AC stepping, within the 16-column windows:
  - Increment: 0x0F -> 0x40, 0x4F -> 0x00.
  - Decrement: 0x00 -> 0x4F, 0x40 -> 0x0F.
  - Otherwise ±1.
- Edge cases:
  - E pulse of one cycle is valid.
  - A reset asserted mid-pulse discards the pending commit, and the falling edge after reset release is ignored (e_q resets to 0).
  - A reset during busy clears busy immediately.

Optional Feature:
- LCD_INIT_CHECK_EN defined: after reset, until the first function-set command is committed, data writes and data reads are dropped: no shadow change, ac unchanged, DB_out = 0. Each one sets a sticky output init_err (1 bit, reset 0). Instruction writes are accepted normally.
- Undefined: no init_err port; all accesses are accepted from reset.

Test Plan:
- Write 0x38, 0x0C, 0x06, 0x01 with each E pulse after busy drops -> two_line = 1, display_on = 1, cursor_on = 0, ac = 0, shadow all 0x20. Busy high exactly CLEAR_CYCLES after 0x01 and BUSY_CYCLES after the others.
- Write 0x80, then data 'A' (0x41) x17 -> shadow[0..15] = 0x41, shadow[16] = 0x41, ac = 0x41.
- Write 0x04 (decrement mode), 0x80, data 0x5A -> shadow[0] = 0x5A, ac = 0x4F.
- Write data while busy = 1 -> shadow unchanged, overrun = 1. Status read while busy -> DB_out = {1, ac}, DB_oe high only while E = 1.
- Write 0xA5 (address 0x25) -> ac = 0x05, addr_err = 1. Data read with RS = 1 returns shadow[5] and ac becomes 0x06.
- Reset asserted during an E-high data write of 0x33 -> no shadow update, busy = 0, all outputs at reset values. With LCD_INIT_CHECK_EN, a data write before 0x38 -> init_err = 1, shadow unchanged.
